// File: rtl/mem_request_unit_if.sv
// Data-memory request/response channel between the Y86-64 memory stage
// (master) and the data memory (slave).
//   mem_req_valid  : request valid (master -> slave)
//   mem_req_ready  : slave accepts request (slave -> master)
//   mem_req_write  : 1 = write, 0 = read
//   mem_req_addr   : word address
//   mem_req_wdata  : write data
//   mem_resp_valid : read data valid (slave -> master)
//   mem_resp_rdata : read data
interface mem_request_unit_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_write;
  logic [63:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_rdata;

  modport master (
    output mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata
  );
endinterface

// File: rtl/mem_request_unit.sv
// Initiator side of the data-memory interface of the pipelined Y86-64 core.
// Decodes icode into read/write requests, issues them on a valid/ready
// channel, collects read responses, and reports valM plus a status code.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   in_valid / in_ready : memory-stage instruction handshake
//   icode, valA, valE, valP : instruction fields, latched on acceptance
//   busy                : stall request to the pipeline
//   out_valid           : one-cycle completion pulse
//   valM, stat          : read data (held) and status (1=AOK, 3=ADR)
//   mem                 : request/response channel (master side)
module mem_request_unit #(
  parameter int unsigned ADDR_LIMIT = 256,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          icode,
  input  logic [63:0]         valA,
  input  logic [63:0]         valE,
  input  logic [63:0]         valP,
  output logic                busy,
  output logic                out_valid,
  output logic [63:0]         valM,
  output logic [2:0]          stat,
  mem_request_unit_if.master  mem
);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [63:0]        valM_q, valM_d;
  logic [2:0]         stat_q, stat_d;
  logic               req_valid_q, req_valid_d;
  logic               req_write_q, req_write_d;
  logic [63:0]        req_addr_q, req_addr_d;
  logic [63:0]        req_wdata_q, req_wdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               dec_mem;
  logic               dec_write;
  logic [63:0]        dec_addr;
  logic [63:0]        dec_wdata;
  logic               dec_adr_err;

  // Instruction decode: which operand forms the address and which the data.
  always_comb begin
    dec_mem   = 1'b0;
    dec_write = 1'b0;
    dec_addr  = valE;
    dec_wdata = valA;
    case (icode)
      4'h4, 4'hA: begin dec_mem = 1'b1; dec_write = 1'b1; end
      4'h8:       begin dec_mem = 1'b1; dec_write = 1'b1; dec_wdata = valP; end
      4'h5:       dec_mem = 1'b1;
      4'h9, 4'hB: begin dec_mem = 1'b1; dec_addr = valA; end
      default:    ;
    endcase
  end

  assign dec_adr_err = (dec_addr >= 64'(ADDR_LIMIT));

  assign in_ready  = (state_q == S_IDLE) && !out_valid_q;
  // out_valid_q covers both DONE and the no-request completion cycle in IDLE
  assign busy      = (state_q != S_IDLE) || out_valid_q;
  assign out_valid = out_valid_q;
  assign valM      = valM_q;
  assign stat      = stat_q;

  assign mem.mem_req_valid = req_valid_q;
  assign mem.mem_req_write = req_write_q;
  assign mem.mem_req_addr  = req_addr_q;
  assign mem.mem_req_wdata = req_wdata_q;

  always_comb begin
    state_d     = state_q;
    out_valid_d = 1'b0;
    valM_d      = valM_q;
    stat_d      = stat_q;
    req_valid_d = req_valid_q;
    req_write_d = req_write_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          if (!dec_mem || dec_adr_err) begin
            // Completes without touching memory; state stays IDLE.
            out_valid_d = 1'b1;
            stat_d      = dec_mem ? STAT_ADR : STAT_AOK;
          end else begin
            state_d     = S_REQ;
            req_valid_d = 1'b1;
            req_write_d = dec_write;
            req_addr_d  = dec_addr;
            req_wdata_d = dec_wdata;
          end
        end
      end
      S_REQ: begin
        if (mem.mem_req_ready) begin
          req_valid_d = 1'b0;
          if (req_write_q) begin
            state_d     = S_DONE;
            stat_d      = STAT_AOK;
            out_valid_d = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end
        end
      end
      S_WAIT: begin
        if (mem.mem_resp_valid) begin
          valM_d      = mem.mem_resp_rdata;
          stat_d      = STAT_AOK;
          state_d     = S_DONE;
          out_valid_d = 1'b1;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // TIMEOUT cycles in WAIT with no response: abort the read.
          stat_d      = STAT_ADR;
          state_d     = S_DONE;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      valM_q      <= '0;
      stat_q      <= STAT_AOK;
      req_valid_q <= 1'b0;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      valM_q      <= valM_d;
      stat_q      <= stat_d;
      req_valid_q <= req_valid_d;
      req_write_q <= req_write_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_request_unit.sv
// Testbench for mem_request_unit: table of directed transactions, reset
// abort sequence, then randomized transactions against a transaction-level
// reference model.
module tb_mem_request_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  icode;
  logic [63:0] valA, valE, valP;
  logic        busy;
  logic        out_valid;
  logic [63:0] valM;
  logic [2:0]  stat;

  mem_request_unit_if mif();

  mem_request_unit #(.ADDR_LIMIT(256), .TIMEOUT(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .icode     (icode),
    .valA      (valA),
    .valE      (valE),
    .valP      (valP),
    .busy      (busy),
    .out_valid (out_valid),
    .valM      (valM),
    .stat      (stat),
    .mem       (mif)
  );

  always #5 clk = ~clk;

  // One transaction: stimulus plus expected behaviour.
  // rdly = cycles mem_req_ready is held low in REQ; ddly = WAIT cycles before
  // the response; lat = posedges after acceptance until out_valid is visible.
  typedef struct {
    logic [3:0]  icode;
    logic [63:0] a, e, p;
    int          rdly, ddly;
    bit          no_resp;
    logic [63:0] rdata;
    bit          req, wr;
    logic [63:0] addr, wdata;
    int          lat;
    logic [2:0]  stat;
    logic [63:0] valm;
  } vec_t;

  int          n_pass = 0;
  int          n_total = 0;
  logic [63:0] m_valm = 64'h0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  function automatic vec_t mkv(logic [3:0] ic, logic [63:0] a, logic [63:0] e, logic [63:0] p,
                               int rdly, int ddly, bit nr, logic [63:0] rdata,
                               bit req, bit wr, logic [63:0] addr, logic [63:0] wdata,
                               int lat, logic [2:0] st, logic [63:0] vm);
    vec_t v;
    v.icode = ic; v.a = a; v.e = e; v.p = p;
    v.rdly = rdly; v.ddly = ddly; v.no_resp = nr; v.rdata = rdata;
    v.req = req; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.lat = lat; v.stat = st; v.valm = vm;
    return v;
  endfunction

  // Reference model: derives the expected outcome from the instruction
  // semantics and the chosen memory timing.
  function automatic vec_t model(logic [3:0] ic, logic [63:0] a, logic [63:0] e, logic [63:0] p,
                                 int rdly, int ddly, bit nr, logic [63:0] rdata);
    vec_t v;
    bit   is_mem = 1'b1;
    v = mkv(ic, a, e, p, rdly, ddly, nr, rdata, 0, 0, 64'h0, 64'h0, 0, 3'd1, 64'h0);
    case (ic)
      4'h4, 4'hA: begin v.wr = 1; v.addr = e; v.wdata = a; end
      4'h8:       begin v.wr = 1; v.addr = e; v.wdata = p; end
      4'h5:       v.addr = e;
      4'h9, 4'hB: v.addr = a;
      default:    is_mem = 1'b0;
    endcase
    if (!is_mem) begin
      v.stat = 3'd1; v.lat = 0;
    end else if (v.addr >= 64'd256) begin
      v.stat = 3'd3; v.lat = 0;
    end else begin
      v.req = 1;
      if (v.wr) begin
        v.lat = 1 + rdly; v.stat = 3'd1;
      end else if (nr) begin
        v.lat = 1 + rdly + 16; v.stat = 3'd3;
      end else begin
        v.lat = 2 + rdly + ddly; v.stat = 3'd1; m_valm = rdata;
      end
    end
    v.valm = m_valm;
    return v;
  endfunction

  task automatic run_txn(input vec_t v, input string tag);
    chk($sformatf("%s in_ready before accept", tag), in_ready, 1);
    in_valid = 1'b1; icode = v.icode; valA = v.a; valE = v.e; valP = v.p;
    mif.mem_req_ready = 1'b0; mif.mem_resp_valid = 1'b0;
    @(posedge clk); #1;
    // Scramble inputs to confirm fields were latched at acceptance.
    in_valid = 1'b0; icode = 4'($urandom); valA = {$urandom, $urandom};
    valE = {$urandom, $urandom}; valP = {$urandom, $urandom};
    for (int t = 0; t <= v.lat + 1; t++) begin
      chk($sformatf("%s t=%0d out_valid", tag, t), out_valid, (t == v.lat));
      chk($sformatf("%s t=%0d busy", tag, t), busy, (t <= v.lat));
      chk($sformatf("%s t=%0d in_ready", tag, t), in_ready, (t > v.lat));
      chk($sformatf("%s t=%0d mem_req_valid", tag, t), mif.mem_req_valid, (v.req && t <= v.rdly));
      if (v.req && t <= v.rdly) begin
        chk($sformatf("%s t=%0d mem_req_write", tag, t), mif.mem_req_write, v.wr);
        chk($sformatf("%s t=%0d mem_req_addr", tag, t), mif.mem_req_addr, v.addr);
        if (v.wr) chk($sformatf("%s t=%0d mem_req_wdata", tag, t), mif.mem_req_wdata, v.wdata);
      end
      if (t >= v.lat) begin
        chk($sformatf("%s t=%0d stat", tag, t), stat, v.stat);
        chk($sformatf("%s t=%0d valM", tag, t), valM, v.valm);
      end
      // Inputs for the next edge.
      mif.mem_req_ready  = (v.req && t < v.rdly) ? 1'b0 :
                           (v.req && t == v.rdly) ? 1'b1 : 1'($urandom);
      mif.mem_resp_rdata = {$urandom, $urandom};
      if (t >= v.lat) begin
        mif.mem_resp_valid = 1'b1;   // stray/late response, must be dropped
      end else if (v.req && t <= v.rdly) begin
        mif.mem_resp_valid = 1'($urandom);  // response during REQ, must be ignored
      end else begin
        mif.mem_resp_valid = (!v.no_resp && t == v.rdly + 1 + v.ddly);
        if (mif.mem_resp_valid) mif.mem_resp_rdata = v.rdata;
      end
      @(posedge clk); #1;
    end
    mif.mem_req_ready = 1'b0; mif.mem_resp_valid = 1'b0;
    // The final loop edge may itself have carried a stray response.
    chk($sformatf("%s valM after stray response", tag), valM, v.valm);
  endtask

  vec_t        tbl[13];
  logic [3:0]  memc[6];

  initial begin
    int pulses;
    reset = 1'b1; in_valid = 1'b0; icode = 4'h0;
    valA = 64'h0; valE = 64'h0; valP = 64'h0;
    mif.mem_req_ready = 1'b0; mif.mem_resp_valid = 1'b0; mif.mem_resp_rdata = 64'h0;

    //        icode  valA        valE              valP   rdly ddly nr rdata    req wr addr     wdata   lat stat valM
    tbl[0]  = mkv(4'h4, 64'hDEAD, 64'h10,          64'h0,  0, 0, 0, 64'h0,    1, 1, 64'h10, 64'hDEAD, 1, 3'd1, 64'h0);
    tbl[1]  = mkv(4'h5, 64'h77,   64'h10,          64'h0,  3, 1, 0, 64'hDEAD, 1, 0, 64'h10, 64'h0,    6, 3'd1, 64'hDEAD);
    tbl[2]  = mkv(4'hB, 64'h20,   64'h28,          64'h0,  0, 0, 0, 64'h1234, 1, 0, 64'h20, 64'h0,    2, 3'd1, 64'h1234);
    tbl[3]  = mkv(4'h8, 64'h99,   64'h30,          64'h44, 0, 0, 0, 64'h0,    1, 1, 64'h30, 64'h44,   1, 3'd1, 64'h1234);
    tbl[4]  = mkv(4'h5, 64'h0,    64'h100,         64'h0,  0, 0, 0, 64'h0,    0, 0, 64'h0,  64'h0,    0, 3'd3, 64'h1234);
    tbl[5]  = mkv(4'h6, 64'h1,    64'h2,           64'h3,  0, 0, 0, 64'h0,    0, 0, 64'h0,  64'h0,    0, 3'd1, 64'h1234);
    tbl[6]  = mkv(4'h9, 64'h40,   64'h0,           64'h0,  0, 0, 1, 64'h0,    1, 0, 64'h40, 64'h0,   17, 3'd3, 64'h1234);
    tbl[7]  = mkv(4'hA, 64'h5555, 64'hFF,          64'h0,  1, 0, 0, 64'h0,    1, 1, 64'hFF, 64'h5555, 2, 3'd1, 64'h1234);
    tbl[8]  = mkv(4'h4, 64'h1,    64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 0, 0, 0, 64'h0, 0, 0, 64'h0, 64'h0, 0, 3'd3, 64'h1234);
    tbl[9]  = mkv(4'h5, 64'h0,    64'hFF,          64'h0,  0, 3, 0, 64'hCAFE, 1, 0, 64'hFF, 64'h0,    5, 3'd1, 64'hCAFE);
    tbl[10] = mkv(4'hB, 64'h100,  64'h8,           64'h0,  0, 0, 0, 64'h0,    0, 0, 64'h0,  64'h0,    0, 3'd3, 64'hCAFE);
    tbl[11] = mkv(4'h3, 64'h0,    64'h0,           64'h0,  0, 0, 0, 64'h0,    0, 0, 64'h0,  64'h0,    0, 3'd1, 64'hCAFE);
    tbl[12] = mkv(4'h9, 64'h8,    64'h0,           64'h0,  2, 15, 0, 64'hABC, 1, 0, 64'h8,  64'h0,   19, 3'd1, 64'hABC);

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset in_ready", in_ready, 1);
    chk("reset busy", busy, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset valM", valM, 0);
    chk("reset stat", stat, 1);
    chk("reset mem_req_valid", mif.mem_req_valid, 0);
    chk("reset mem_req_write", mif.mem_req_write, 0);
    chk("reset mem_req_addr", mif.mem_req_addr, 0);
    chk("reset mem_req_wdata", mif.mem_req_wdata, 0);

    for (int i = 0; i < 13; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Reset while a read sits in WAIT: abort without completion.
    in_valid = 1'b1; icode = 4'h9; valA = 64'h18; valE = 64'h0; valP = 64'h0;
    mif.mem_req_ready = 1'b1;
    @(posedge clk); #1;           // accepted, REQ
    in_valid = 1'b0;
    @(posedge clk); #1;           // handshake, WAIT
    mif.mem_req_ready = 1'b0;
    chk("rstwait busy in WAIT", busy, 1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rstwait in_ready", in_ready, 1);
    chk("rstwait mem_req_valid", mif.mem_req_valid, 0);
    chk("rstwait out_valid", out_valid, 0);
    chk("rstwait busy", busy, 0);
    chk("rstwait valM", valM, 0);
    pulses = 0;
    for (int c = 0; c < 24; c++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    chk("rstwait no completion pulse", pulses, 0);
    m_valm = 64'h0;
    run_txn(mkv(4'h4, 64'h1111, 64'h8, 64'h0, 0, 0, 0, 64'h0, 1, 1, 64'h8, 64'h1111, 1, 3'd1, 64'h0),
            "post_reset_rmmovq");

    // Randomized transactions.
    memc[0] = 4'h4; memc[1] = 4'h5; memc[2] = 4'h8;
    memc[3] = 4'h9; memc[4] = 4'hA; memc[5] = 4'hB;
    for (int n = 0; n < 40; n++) begin
      logic [3:0]  ic;
      logic [63:0] a, e, p;
      ic = ($urandom_range(0, 9) < 8) ? memc[$urandom_range(0, 5)] : 4'($urandom_range(0, 15));
      a = ($urandom_range(0, 4) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 300));
      e = ($urandom_range(0, 4) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 300));
      p = {$urandom, $urandom};
      run_txn(model(ic, a, e, p, $urandom_range(0, 3), $urandom_range(0, 4),
                    ($urandom_range(0, 7) == 0), {$urandom, $urandom}),
              $sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_request_unit.md
Name: mem_request_unit

Overview:
- Initiator side of the data-memory interface for the pipelined Y86-64 core. It sits between the memory-stage pipeline register and the data memory.
- Decodes icode into read or write requests, drives a valid/ready request channel, and collects read responses.
- Returns valM and a status code, and holds the pipeline busy while a transaction is in flight.

Parameters:
- ADDR_LIMIT, 256: number of valid word addresses; any address >= ADDR_LIMIT is an address error.
- TIMEOUT, 16: cycles in WAIT without mem_resp_valid before the read is aborted with ADR.

Ports:
- clk  input  1  clock; all logic on posedge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  memory-stage instruction present
- in_ready  output  1  unit can accept an instruction (state IDLE)
- icode  input  4  instruction code
- valA  input  64  register operand
- valE  input  64  ALU result
- valP  input  64  next PC
- busy  output  1  stall request to pipeline
- out_valid  output  1  one-cycle completion pulse
- valM  output  64  read data, held until next completion
- stat  output  3  1=AOK, 3=ADR
- mem_req_valid  output  1  request valid
- mem_req_ready  input  1  memory accepts request
- mem_req_write  output  1  1=write, 0=read
- mem_req_addr  output  64  word address
- mem_req_wdata  output  64  write data
- mem_resp_valid  input  1  read data valid
- mem_resp_rdata  input  64  read data

Behaviour:
- Reset: state=IDLE. in_ready=1, busy=0, out_valid=0, valM=0, stat=1, mem_req_valid=0, mem_req_write=0, mem_req_addr=0, mem_req_wdata=0, timeout counter=0.
- Decode:
  - Writes: rmmovq (4) addr=valE, data=valA; pushq (A) addr=valE, data=valA; call (8) addr=valE, data=valP.
  - Reads: mrmovq (5) addr=valE; popq (B) addr=valA; ret (9) addr=valA.
  - Every other icode is non-memory.
- Acceptance: occurs on a posedge with in_valid & in_ready. All fields are latched at that edge. in_valid while not in IDLE is ignored.
- Non-memory instruction, or memory instruction with addr >= ADDR_LIMIT (unsigned 64-bit compare):
  - No request is issued.
  - Next cycle: out_valid=1; stat=1 for non-memory, 3 for ADR; valM unchanged.
  - State returns to IDLE.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - On a valid memory acceptance, go to REQ.
  - mem_req_valid, mem_req_write, mem_req_addr and mem_req_wdata are registered and asserted from the cycle after acceptance.
- REQ:
  - Request fields are held stable until a posedge with mem_req_ready=1.
  - On that edge, a write goes to DONE with stat=1; a read goes to WAIT with the counter cleared.
  - mem_req_valid drops in the cycle after the handshake.
  - mem_resp_valid in REQ is ignored.
- WAIT:
  - Posedge with mem_resp_valid: valM<=mem_resp_rdata, stat<=1, go to DONE.
  - Otherwise the counter increments. When it reaches TIMEOUT-1 with no response: stat<=3, valM unchanged, go to DONE.
- DONE: out_valid=1 for exactly one cycle, then IDLE.
- busy=1 in REQ, WAIT and DONE, and in the single completion cycle of the no-request path. in_ready = (state==IDLE) & ~out_valid.
- Latency:
  - No-request path: out_valid 1 cycle after acceptance.
  - Write with mem_req_ready tied high: out_valid 2 cycles after acceptance.
  - Read with 1-cycle memory: out_valid 3 cycles after acceptance.
- mem_resp_valid in IDLE or DONE, including a late response after timeout, is dropped without effect.
- Reset mid-transaction returns to IDLE immediately. mem_req_valid=0 the next cycle. No out_valid is produced for the aborted instruction.
- Only one outstanding transaction is allowed. No back-to-back acceptance in the out_valid cycle.

Test Plan:
- Reset, then rmmovq (4) with valE=0x10, valA=0xDEAD, mem_req_ready=1 -> write request addr 0x10, wdata 0xDEAD, write=1. out_valid 2 cycles after acceptance, stat=1.
- mrmovq (5) with valE=0x10, mem_req_ready stalled 3 cycles, response 0xDEAD 2 cycles after handshake -> request fields stable throughout; busy high; valM=0xDEAD; stat=1; single out_valid pulse.
- popq (B) with valA=0x20, valE=0x28 -> mem_req_addr=0x20; call (8) with valE=0x30, valP=0x44 -> wdata=0x44 at addr 0x30.
- mrmovq with valE=0x100 (ADDR_LIMIT=256) -> no mem_req_valid; out_valid next cycle, stat=3. opq (6) -> out_valid next cycle, stat=1, valM unchanged.
- ret (9) with no response for 16 cycles -> stat=3 and out_valid. A response arriving after that is ignored and valM is unchanged.
- Reset asserted in WAIT -> next cycle IDLE, mem_req_valid=0, out_valid=0, busy=0. A subsequent rmmovq completes normally.
